psum_write_back: RTL and testbench
==================================

// Module: psum_write_back
// PURPOSE
// - Partial-sum accumulation and output write-back stage of the CNN accelerator PE array.
// - Holds one DEPTH-entry psum buffer per PE-array output row; every valid beat adds the four PE partial sums of that row into the current column entry.
// - After the final filter pass it drains all rows to two output ports (two rows per column), clears the buffers and re-arms the conv engine.
// PARAMETERS
// - DATA_W    25  psum / output word width, two's complement
// - DEPTH      8  entries per row buffer (= output columns per tile)
// - ADDR_W     3  buffer address width, clog2(DEPTH)
// - NUM_ROWS   5  row buffers (output rows per tile)
// PORTS
// - clk           in   1                 system clock, all logic on rising edge
// - rst_n         in   1                 synchronous, active-high reset (codebase port name kept; 1 = reset)
// - start_init    in   1                 pulse: clear all buffers, then start conv
// - p_valid_data  in   1                 one beat of PE partial sums present
// - p_filter_end  in   1                 qualifies beat as part of the final filter pass
// - pe_data       in   NUM_ROWS*4*DATA_W row r, PE k at [(r*4+k)*DATA_W +: DATA_W]
// - out_port0     out  DATA_W            write-back data, even row of pair
// - out_port1     out  DATA_W            write-back data, odd row of pair
// - port0_valid   out  1                 out_port0 valid this cycle
// - port1_valid   out  1                 out_port1 valid this cycle
// - start_conv    out  1                 one-cycle pulse: buffers zeroed, accept next tile
// BEHAVIOUR
// - States: IDLE, INIT, ACCUM, DRAIN, DONE. Reset: IDLE, wptr=0, all outputs 0; buffer contents not reset.
// - IDLE: p_valid_data ignored. start_init=1 -> INIT.
// - INIT: clears address a (all rows) in cycle a, a=0..DEPTH-1, then DONE. start_init in any state restarts INIT at a=0.
// - DONE: start_conv=1 for exactly one cycle, wptr=0, -> ACCUM.
// - ACCUM, beat (p_valid_data=1): for each row r, buf[r][wptr] <= buf[r][wptr] + pe[r][0]+pe[r][1]+pe[r][2]+pe[r][3];
//   sum mod 2^DATA_W; wptr <= wptr+1, wraps DEPTH-1 -> 0. No beat: nothing changes.
// - Beat with p_filter_end=1 at wptr=DEPTH-1: after the write, -> DRAIN (next cycle, rd=0, phase=0).
// - p_filter_end on beats at other addresses only marks the pass; it does not trigger DRAIN.
// - DRAIN, one column per cycle, read shows the fully written value (incl. last beat):
//   phase0: port0=row0[rd], port1=row1[rd], both valid; phase1: rows 2/3 likewise;
//   phase2: port0=row4[rd] valid, port1=0, port1_valid=0.
//   rd 0..DEPTH-1 per phase; each read entry is zeroed the same cycle; after phase2 rd=DEPTH-1 -> DONE.
// - Drain length NUM_ROWS odd: ceil(NUM_ROWS/2)*DEPTH cycles (24 at defaults); last phase single-port.
// - p_valid_data during INIT/DRAIN/DONE is dropped (no write, no wptr change).
// - Outputs registered; port data 0 whenever its valid is 0.
// - Reset mid-operation: next cycle all outputs 0, state IDLE; start_init required before new data.
// CONFIGURATION
// - PSUM_SAT_EN defined: accumulation saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1] instead of wrapping (incl. intermediate 4-PE sum).
// - PSUM_SAT_EN undefined: plain modulo-2^DATA_W wrap-around addition.
// TESTING
// - Reset then start_init pulse -> start_conv high exactly 1 cycle, DEPTH+1 cycles after start_init; ports invalid.
// - Beats before start_init -> ignored; later drain of a pass of zeros outputs all 0.
// - 8 beats (1,1,1,2),(1,k,2,2) k=2..8 with p_filter_end -> drain column 0=5, column c=6+c; ports equal; 8+8+8 cycles; port1_valid=0 in phase2.
// - Two plain passes + one filter_end pass of same data -> column 0=15, column c=3*(6+c) (21..39); then start_conv pulse.
// - Second tile after drain with same 3 passes -> identical values (buffers were zeroed); beats during drain dropped.
// - PSUM_SAT_EN: accumulate 2^24-1 plus 1 -> 2^24-1 saturated; without macro -> -2^24 wrapped.

Source files
------------

// File: rtl/psum_write_back_if.sv
// Handshake bundle between the PE array / conv engine and the partial-sum write-back stage.
interface psum_write_back_if #(
   parameter int DATA_W   = 25,
   parameter int NUM_ROWS = 5
);
   logic                         start_init;
   logic                         p_valid_data;
   logic                         p_filter_end;
   logic [NUM_ROWS*4*DATA_W-1:0] pe_data;
   logic [DATA_W-1:0]            out_port0;
   logic [DATA_W-1:0]            out_port1;
   logic                         port0_valid;
   logic                         port1_valid;
   logic                         start_conv;

   modport master (
      output start_init, p_valid_data, p_filter_end, pe_data,
      input  out_port0, out_port1, port0_valid, port1_valid, start_conv
   );

   modport slave (
      input  start_init, p_valid_data, p_filter_end, pe_data,
      output out_port0, out_port1, port0_valid, port1_valid, start_conv
   );
endinterface

// File: rtl/psum_write_back.sv
// Psum row-buffer accumulate + two-port drain; outputs registered (1 cycle), no backpressure: beats outside ACCUM are dropped.
// Define PSUM_SAT_EN for saturating accumulation; default build wraps modulo 2^DATA_W.
module psum_write_back #(
   parameter int DATA_W   = 25,
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = 3,
   parameter int NUM_ROWS = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   psum_write_back_if.slave bus
);
   localparam int NUM_PH = (NUM_ROWS + 1) / 2;
   localparam int PH_W   = (NUM_PH > 1) ? $clog2(NUM_PH) : 1;
   localparam int EXT_W  = DATA_W + 3;

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_ACCUM, S_DRAIN, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [PH_W-1:0]     r_phase;
   logic [ADDR_W-1:0]   r_wptr;
   logic [DATA_W-1:0]   r_buf [NUM_ROWS][DEPTH];

   logic                w_beat;
   logic                w_last_col;
   logic                w_last_ph;
   logic                w_wptr_last;
   logic                w_chg;
   logic signed [EXT_W-1:0] w_pe_sum [NUM_ROWS];
   logic [DATA_W-1:0]   w_acc [NUM_ROWS];

   logic                w_p0_vld, w_p1_vld, w_start_conv;
   logic [DATA_W-1:0]   w_p0_dat, w_p1_dat;
   logic                r_p0_vld, r_p1_vld, r_start_conv;
   logic [DATA_W-1:0]   r_p0_dat, r_p1_dat;

   function automatic logic signed [EXT_W-1:0] sext(input logic [DATA_W-1:0] v);
      return {{(EXT_W-DATA_W){v[DATA_W-1]}}, v};
   endfunction

`ifdef PSUM_SAT_EN
   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   function automatic logic [DATA_W-1:0] sat(input logic signed [EXT_W-1:0] v);
      if (v > sext(SAT_MAX)) return SAT_MAX;
      if (v < sext(SAT_MIN)) return SAT_MIN;
      return v[DATA_W-1:0];
   endfunction
`endif

   assign w_beat      = (r_state == S_ACCUM) && bus.p_valid_data && !bus.start_init;
   assign w_last_col  = (int'(r_addr) == DEPTH - 1);
   assign w_last_ph   = (int'(r_phase) == NUM_PH - 1);
   assign w_wptr_last = (int'(r_wptr) == DEPTH - 1);
   assign w_chg       = bus.start_init || (w_state_nxt != r_state);

   // rst_n is active-high: 1 holds the block in reset
   always_ff @(posedge clk) begin
      if (rst_n) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.start_init) begin
         w_state_nxt = S_INIT;
      end else begin
         case (r_state)
            S_INIT:  if (w_last_col) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_beat && bus.p_filter_end && w_wptr_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_col && w_last_ph) w_state_nxt = S_DONE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // r_addr is the clear address in INIT and the read column in DRAIN
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_addr  <= '0;
         r_phase <= '0;
         r_wptr  <= '0;
      end else begin
         if (w_chg) begin
            r_addr  <= '0;
            r_phase <= '0;
         end else if (r_state == S_INIT || r_state == S_DRAIN) begin
            r_addr <= w_last_col ? '0 : r_addr + 1'b1;
            if (r_state == S_DRAIN && w_last_col) r_phase <= r_phase + 1'b1;
         end
         if (r_state == S_DONE)  r_wptr <= '0;
         else if (w_beat)        r_wptr <= w_wptr_last ? '0 : r_wptr + 1'b1;
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_ROWS; r++) begin
         w_pe_sum[r] = '0;
         for (int k = 0; k < 4; k++)
            w_pe_sum[r] = w_pe_sum[r] + sext(bus.pe_data[(r*4+k)*DATA_W +: DATA_W]);
`ifdef PSUM_SAT_EN
         w_acc[r] = sat(sext(sat(w_pe_sum[r])) + sext(r_buf[r][r_wptr]));
`else
         w_acc[r] = DATA_W'(w_pe_sum[r] + sext(r_buf[r][r_wptr]));
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n && !bus.start_init) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            if (r_state == S_INIT)
               r_buf[r][r_addr] <= '0;
            else if (w_beat)
               r_buf[r][r_wptr] <= w_acc[r];
            else if (r_state == S_DRAIN && (r / 2) == int'(r_phase))
               r_buf[r][r_addr] <= '0;
         end
      end
   end

   always_comb begin
      w_p0_vld     = 1'b0;
      w_p1_vld     = 1'b0;
      w_p0_dat     = '0;
      w_p1_dat     = '0;
      w_start_conv = (r_state == S_DONE) && !bus.start_init;
      if (r_state == S_DRAIN && !bus.start_init) begin
         w_p0_vld = 1'b1;
         for (int r = 0; r < NUM_ROWS; r++) begin
            if ((r / 2) == int'(r_phase)) begin
               if ((r % 2) == 0) begin
                  w_p0_dat = r_buf[r][r_addr];
               end else begin
                  w_p1_vld = 1'b1;
                  w_p1_dat = r_buf[r][r_addr];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_p0_vld     <= 1'b0;
         r_p1_vld     <= 1'b0;
         r_p0_dat     <= '0;
         r_p1_dat     <= '0;
         r_start_conv <= 1'b0;
      end else begin
         r_p0_vld     <= w_p0_vld;
         r_p1_vld     <= w_p1_vld;
         r_p0_dat     <= w_p0_dat;
         r_p1_dat     <= w_p1_dat;
         r_start_conv <= w_start_conv;
      end
   end

   assign bus.out_port0   = r_p0_dat;
   assign bus.out_port1   = r_p1_dat;
   assign bus.port0_valid = r_p0_vld;
   assign bus.port1_valid = r_p1_vld;
   assign bus.start_conv  = r_start_conv;
endmodule

// File: tb/tb_psum_write_back.sv
// Bench for psum_write_back: table-driven tiles, directed corner sequences and random tiles vs a row/column array model.
module tb_psum_write_back;
   localparam int DW    = 25;
   localparam int DEPTH = 8;
   localparam int NR    = 5;
   localparam int PEW   = NR * 4 * DW;
   localparam longint MOD  = 64'sd1 <<< DW;
   localparam longint HALF = 64'sd1 <<< (DW - 1);
`ifdef PSUM_SAT_EN
   localparam logic [31:0] OVF_EXP = 32'h00FF_FFFF;
`else
   localparam logic [31:0] OVF_EXP = 32'h0100_0000;
`endif

   typedef struct { int a; int b; int c; int d; int exp; } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   psum_write_back_if #(.DATA_W(DW), .NUM_ROWS(NR)) bus ();

   psum_write_back #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(3), .NUM_ROWS(NR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int            checks = 0;
   int            errors = 0;
   longint        mdl [NR][DEPTH];
   int            mdl_wptr = 0;
   vec_t          tbl [DEPTH];
   logic [DW-1:0] first_p0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic longint red(input longint v);
`ifdef PSUM_SAT_EN
      if (v > HALF - 1) return HALF - 1;
      if (v < -HALF) return -HALF;
      return v;
`else
      longint m;
      m = v % MOD;
      if (m < 0) m += MOD;
      if (m >= HALF) m -= MOD;
      return m;
`endif
   endfunction

   function automatic logic [31:0] to_dw(input longint v);
      return {7'b0, v[DW-1:0]};
   endfunction

   function automatic logic [PEW-1:0] mk_pe(input int a, input int b, input int c, input int d);
      logic [PEW-1:0] v;
      for (int r = 0; r < NR; r++) begin
         v[(r*4+0)*DW +: DW] = DW'(a);
         v[(r*4+1)*DW +: DW] = DW'(b);
         v[(r*4+2)*DW +: DW] = DW'(c);
         v[(r*4+3)*DW +: DW] = DW'(d);
      end
      return v;
   endfunction

   function automatic logic [PEW-1:0] rnd_pe(input bit big);
      logic [PEW-1:0] v;
      for (int i = 0; i < NR * 4; i++)
         v[i*DW +: DW] = big ? DW'($urandom) : DW'($urandom_range(0, 2000) - 1000);
      return v;
   endfunction

   task automatic clear_model();
      foreach (mdl[r, c]) mdl[r][c] = 0;
      mdl_wptr = 0;
   endtask

   // One accepted beat: each row entry gains the sum of its four PEs.
   task automatic beat(input logic [PEW-1:0] pe, input bit fe);
      longint        s;
      logic [DW-1:0] f;
      bus.pe_data      = pe;
      bus.p_valid_data = 1'b1;
      bus.p_filter_end = fe;
      for (int r = 0; r < NR; r++) begin
         s = 0;
         for (int k = 0; k < 4; k++) begin
            f = pe[(r*4+k)*DW +: DW];
            s += longint'(signed'(f));
         end
`ifdef PSUM_SAT_EN
         s = red(s);
`endif
         mdl[r][mdl_wptr] = red(mdl[r][mdl_wptr] + s);
      end
      mdl_wptr = (mdl_wptr + 1) % DEPTH;
      step();
      bus.p_valid_data = 1'b0;
      bus.p_filter_end = 1'b0;
   endtask

   task automatic ignored_beats(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         bus.p_valid_data = 1'b1;
         bus.p_filter_end = 1'b1;
         bus.pe_data      = rnd_pe(1'b1);
         step();
         chk($sformatf("%s p0_vld #%0d", tag, i), bus.port0_valid, 0);
         chk($sformatf("%s start_conv #%0d", tag, i), bus.start_conv, 0);
      end
      bus.p_valid_data = 1'b0;
      bus.p_filter_end = 1'b0;
   endtask

   task automatic do_init(input string tag);
      bus.start_init = 1'b1;
      step();
      bus.start_init = 1'b0;
      for (int i = 1; i <= DEPTH + 1; i++) begin
         bus.p_valid_data = 1'b1;
         bus.p_filter_end = 1'b1;
         bus.pe_data      = rnd_pe(1'b1);
         step();
         chk($sformatf("%s start_conv @%0d", tag, i), bus.start_conv, (i == DEPTH + 1));
         chk($sformatf("%s p0_vld @%0d", tag, i), bus.port0_valid, 0);
      end
      bus.p_valid_data = 1'b0;
      bus.p_filter_end = 1'b0;
      step();
      chk($sformatf("%s start_conv after pulse", tag), bus.start_conv, 0);
      clear_model();
   endtask

   // mult > 0: expected column values come from the table times mult; else from the model.
   task automatic check_drain(input string tag, input int mult, input bit junk);
      logic [31:0] e0, e1;
      bit          has1;
      for (int ph = 0; ph < (NR + 1) / 2; ph++) begin
         for (int c = 0; c < DEPTH; c++) begin
            if (junk) begin
               bus.p_valid_data = 1'b1;
               bus.pe_data      = rnd_pe(1'b1);
            end
            step();
            has1 = (2 * ph + 1 < NR);
            e1   = 0;
            if (mult > 0) begin
               e0 = 32'(tbl[c].exp * mult);
               if (has1) e1 = e0;
            end else begin
               e0 = to_dw(mdl[2*ph][c]);
               if (has1) e1 = to_dw(mdl[2*ph+1][c]);
            end
            if (ph == 0 && c == 0) first_p0 = bus.out_port0;
            chk($sformatf("%s p0_vld ph%0d c%0d", tag, ph, c), bus.port0_valid, 1);
            chk($sformatf("%s port0 ph%0d c%0d", tag, ph, c), bus.out_port0, e0);
            chk($sformatf("%s p1_vld ph%0d c%0d", tag, ph, c), bus.port1_valid, has1);
            chk($sformatf("%s port1 ph%0d c%0d", tag, ph, c), bus.out_port1, e1);
            chk($sformatf("%s start_conv ph%0d c%0d", tag, ph, c), bus.start_conv, 0);
            mdl[2*ph][c] = 0;
            if (has1) mdl[2*ph+1][c] = 0;
         end
      end
      bus.p_valid_data = 1'b0;
      step();
      chk($sformatf("%s start_conv after drain", tag), bus.start_conv, 1);
      chk($sformatf("%s p0_vld after drain", tag), bus.port0_valid, 0);
      chk($sformatf("%s p1_vld after drain", tag), bus.port1_valid, 0);
      mdl_wptr = 0;
   endtask

   task automatic rand_tile(input string tag, input bit big);
      int np;
      bit fe;
      np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) begin
         for (int c = 0; c < DEPTH; c++) begin
            repeat ($urandom_range(0, 2)) begin
               bus.pe_data = rnd_pe(big);
               step();
            end
            if (c == DEPTH - 1) fe = (p == np - 1);
            else                fe = ($urandom_range(0, 3) == 0);
            beat(rnd_pe(big), fe);
         end
      end
      check_drain(tag, 0, bit'($urandom_range(0, 1)));
   endtask

   initial begin
      bus.start_init   = 1'b0;
      bus.p_valid_data = 1'b0;
      bus.p_filter_end = 1'b0;
      bus.pe_data      = '0;
      tbl = '{'{1, 1, 1, 2, 5},  '{1, 2, 2, 2, 7},  '{1, 3, 2, 2, 8},  '{1, 4, 2, 2, 9},
              '{1, 5, 2, 2, 10}, '{1, 6, 2, 2, 11}, '{1, 7, 2, 2, 12}, '{1, 8, 2, 2, 13}};
      clear_model();

      rst_n = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      chk("reset port0", bus.out_port0, 0);
      chk("reset port1", bus.out_port1, 0);
      chk("reset p0_vld", bus.port0_valid, 0);
      chk("reset p1_vld", bus.port1_valid, 0);
      chk("reset start_conv", bus.start_conv, 0);

      ignored_beats("idle", 10);
      do_init("init0");

      for (int c = 0; c < DEPTH; c++) beat('0, c == DEPTH - 1);
      check_drain("zeros", 0, 0);

      for (int c = 0; c < DEPTH; c++)
         beat(mk_pe(tbl[c].a, tbl[c].b, tbl[c].c, tbl[c].d), 1'b1);
      check_drain("tbl1", 1, 0);

      for (int t = 0; t < 2; t++) begin
         for (int p = 0; p < 3; p++)
            for (int c = 0; c < DEPTH; c++)
               beat(mk_pe(tbl[c].a, tbl[c].b, tbl[c].c, tbl[c].d), p == 2);
         check_drain($sformatf("tbl3 tile%0d", t), 3, t == 0);
      end

      for (int c = 0; c < DEPTH; c++) beat((c == 0) ? mk_pe(16777215, 0, 0, 0) : '0, 1'b0);
      for (int c = 0; c < DEPTH; c++) beat((c == 0) ? mk_pe(1, 0, 0, 0) : '0, c == DEPTH - 1);
      check_drain("ovf", 0, 0);
      chk("ovf col0 value", first_p0, OVF_EXP);

      for (int t = 0; t < 4; t++) rand_tile($sformatf("rand%0d", t), t[0]);

      // start_init in the middle of a drain restarts the clear sequence
      for (int c = 0; c < DEPTH; c++) beat(rnd_pe(1'b0), c == DEPTH - 1);
      repeat (5) step();
      do_init("restart");
      rand_tile("post_restart", 1'b0);

      for (int c = 0; c < 3; c++) beat(rnd_pe(1'b0), 1'b0);
      rst_n            = 1'b1;
      bus.p_valid_data = 1'b1;
      step();
      rst_n            = 1'b0;
      bus.p_valid_data = 1'b0;
      chk("midrst port0", bus.out_port0, 0);
      chk("midrst p0_vld", bus.port0_valid, 0);
      chk("midrst p1_vld", bus.port1_valid, 0);
      chk("midrst start_conv", bus.start_conv, 0);
      ignored_beats("post_rst", 10);
      do_init("init1");
      rand_tile("post_rst_tile", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
